// File: rtl/vproc_deq_serializer.sv
`default_nettype none
// ============================================================================
// Module   : vproc_deq_serializer
// Brief    : Dequeues one wide entry at a time and emits it as a sequence of
//            OUT_W-bit beats. Sustains one beat per cycle; the next entry
//            loads in the same cycle the last beat of the current one leaves.
// Revision : 1.0 - initial release
// ============================================================================
module vproc_deq_serializer #(
    parameter int IN_W  = 64,
    parameter int OUT_W = 16
) (
    input  logic                                 clk_i,
    input  logic                                 sync_rst_i,
    // upstream queue side
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic [IN_W-1:0]                      in_data_i,
    input  logic [$clog2(IN_W/OUT_W)-1:0]        in_last_i,
    // downstream beat side
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [OUT_W-1:0]                     out_data_o,
    output logic                                 out_first_o,
    output logic                                 out_last_o,
    output logic                                 busy_o
);

    localparam int c_R     = IN_W / OUT_W;
    localparam int c_IDX_W = $clog2(c_R);

    // An entry must split into a whole number of beats, at least two of them.
    generate
        if (((IN_W % OUT_W) != 0) || (c_R < 2)) begin : g_bad_params
            $error("vproc_deq_serializer: IN_W must be a multiple of OUT_W with IN_W/OUT_W >= 2");
        end
    endgenerate

    logic                          r_valid;
    logic [IN_W-1:0]               r_data;
    logic [c_IDX_W-1:0]            r_last;
    logic [c_IDX_W-1:0]            r_idx;

    logic [c_R-1:0][OUT_W-1:0]     w_beats;
    logic                          w_at_last;
    logic                          w_xfer;
    logic                          w_accept;

    // Beat view of the held entry, beat k at bits [k*OUT_W +: OUT_W].
    assign w_beats     = r_data;
    assign w_at_last   = (r_idx == r_last);
    assign w_xfer      = r_valid & out_ready_i;

    assign out_valid_o = r_valid;
    assign busy_o      = r_valid;
    assign out_data_o  = w_beats[r_idx];
    assign out_first_o = r_valid & (r_idx == '0);
    assign out_last_o  = r_valid & w_at_last;

    // Ready when empty, or when the last beat is leaving this cycle; in_valid_i
    // deliberately plays no part so there is no valid->ready loop upstream.
    assign in_ready_o  = ~r_valid | (out_last_o & out_ready_i);
    assign w_accept    = in_valid_i & in_ready_o;

    // Control state: accept has priority over beat advance so entries chain
    // without an idle cycle; reset discards any partially sent entry.
    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_last  <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_idx   <= '0;
            r_last  <= in_last_i;
        end else if (w_xfer) begin
            if (!w_at_last) begin
                r_idx <= r_idx + 1'b1;
            end else begin
                r_valid <= 1'b0;
                r_idx   <= '0;
            end
        end
    end

    // Entry payload; only meaningful while r_valid, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_data <= in_data_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vproc_deq_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vproc_deq_serializer
// Brief    : Self-checking bench: directed vector table, reset-mid-entry
//            sequence, and randomized traffic against a beat-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vproc_deq_serializer;

    localparam int IN_W  = 64;
    localparam int OUT_W = 16;
    localparam int LW    = 2;

    logic              clk_i = 1'b0;
    logic              sync_rst_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [IN_W-1:0]   in_data_i;
    logic [LW-1:0]     in_last_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [OUT_W-1:0]  out_data_o;
    logic              out_first_o;
    logic              out_last_o;
    logic              busy_o;

    vproc_deq_serializer #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk_i       (clk_i),
        .sync_rst_i  (sync_rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_first_o (out_first_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance one clock; outputs settle 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic            v;
        logic [63:0]     d;
        logic [LW-1:0]   l;
        logic            rdy;
        logic            ev;
        logic [15:0]     ed;
        logic            ef;
        logic            el;
        logic            eir;
    } vec_t;

    vec_t tbl[19];

    typedef struct {
        logic [15:0] d;
        logic        f;
        logic        l;
    } beat_t;

    beat_t q[$];

    localparam logic [63:0] E1 = 64'hDDDD_CCCC_BBBB_AAAA;
    localparam logic [63:0] E2 = 64'h9999_8888_2222_1111;
    localparam logic [63:0] E3 = 64'h5555_6666_7777_1234;
    localparam logic [63:0] E4 = 64'h4444_3333_2222_0F0F;
    localparam logic [63:0] E5 = 64'h0D0D_0C0C_0B0B_0A0A;
    localparam logic [63:0] E6 = 64'hF00D_BEEF_5A5A_C3C3;

    initial begin
        int    pushed;
        int    dut_beats;
        bit    exp_ir;
        beat_t b;

        //            v  data  l     rdy  ev  data      f     l     ir
        tbl[0]  = '{1'b1, E1, 2'd3, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, E2, 2'd1, 1'b1, 1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, E2, 2'd1, 1'b1, 1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, E2, 2'd1, 1'b1, 1'b1, 16'hCCCC, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, E2, 2'd1, 1'b1, 1'b1, 16'hDDDD, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, E3, 2'd0, 1'b1, 1'b1, 16'h1111, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, E3, 2'd0, 1'b1, 1'b1, 16'h2222, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, E4, 2'd3, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 64'h0, 2'd0, 1'b1, 1'b1, 16'h0F0F, 1'b1, 1'b0, 1'b0};
        for (int i = 9; i < 14; i++)
            tbl[i] = '{1'b0, 64'h0, 2'd0, 1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 64'h0, 2'd0, 1'b1, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 64'h0, 2'd0, 1'b1, 1'b1, 16'h3333, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 64'h0, 2'd0, 1'b0, 1'b1, 16'h4444, 1'b0, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 64'h0, 2'd0, 1'b1, 1'b1, 16'h4444, 1'b0, 1'b1, 1'b1};
        tbl[18] = '{1'b0, 64'h0, 2'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};

        // ---------------- reset ----------------
        sync_rst_i  = 1'b1;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        in_last_i   = '0;
        out_ready_i = 1'b0;
        repeat (3) tick();
        sync_rst_i = 1'b0;

        // ---------------- directed table ----------------
        for (int i = 0; i < 19; i++) begin
            in_valid_i  = tbl[i].v;
            in_data_i   = tbl[i].d;
            in_last_i   = tbl[i].l;
            out_ready_i = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d_valid", i), {63'b0, out_valid_o}, {63'b0, tbl[i].ev});
            chk($sformatf("tbl%0d_busy", i),  {63'b0, busy_o},      {63'b0, tbl[i].ev});
            chk($sformatf("tbl%0d_first", i), {63'b0, out_first_o}, {63'b0, tbl[i].ef});
            chk($sformatf("tbl%0d_last", i),  {63'b0, out_last_o},  {63'b0, tbl[i].el});
            chk($sformatf("tbl%0d_inrdy", i), {63'b0, in_ready_o},  {63'b0, tbl[i].eir});
            if (tbl[i].ev)
                chk($sformatf("tbl%0d_data", i), {48'b0, out_data_o}, {48'b0, tbl[i].ed});
            tick();
        end

        // ---------------- reset while holding beat 2 of 4 ----------------
        in_valid_i  = 1'b1;
        in_data_i   = E5;
        in_last_i   = 2'd3;
        out_ready_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        tick();
        tick();
        #1;
        chk("rst_pre_data", {48'b0, out_data_o}, {48'b0, 16'h0C0C});
        sync_rst_i = 1'b1;
        in_valid_i = 1'b1;          // reset must win over this accept
        in_data_i  = E6;
        in_last_i  = 2'd1;
        tick();
        sync_rst_i = 1'b0;
        in_valid_i = 1'b0;
        #1;
        chk("rst_valid", {63'b0, out_valid_o}, 64'd0);
        chk("rst_inrdy", {63'b0, in_ready_o},  64'd1);
        chk("rst_first", {63'b0, out_first_o}, 64'd0);
        chk("rst_last",  {63'b0, out_last_o},  64'd0);
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        #1;
        chk("post_rst_b0",    {48'b0, out_data_o}, {48'b0, 16'hC3C3});
        chk("post_rst_first", {63'b0, out_first_o}, 64'd1);
        tick();
        chk("post_rst_b1",    {48'b0, out_data_o}, {48'b0, 16'h5A5A});
        chk("post_rst_last",  {63'b0, out_last_o}, 64'd1);
        tick();
        chk("post_rst_empty", {63'b0, out_valid_o}, 64'd0);

        // ---------------- randomized traffic vs beat-queue model ----------------
        q.delete();
        pushed    = 0;
        dut_beats = 0;
        for (int c = 0; c < 10000; c++) begin
            in_valid_i  = ($urandom_range(0, 9) < 6);
            in_data_i   = {$urandom, $urandom};
            in_last_i   = LW'($urandom_range(0, 3));
            out_ready_i = ($urandom_range(0, 9) < 7);
            #1;
            exp_ir = (q.size() == 0) || (q.size() == 1 && out_ready_i);
            chk("rnd_valid", {63'b0, out_valid_o}, {63'b0, q.size() != 0});
            chk("rnd_inrdy", {63'b0, in_ready_o},  {63'b0, exp_ir});
            if (q.size() != 0) begin
                chk("rnd_data",  {48'b0, out_data_o},  {48'b0, q[0].d});
                chk("rnd_first", {63'b0, out_first_o}, {63'b0, q[0].f});
                chk("rnd_last",  {63'b0, out_last_o},  {63'b0, q[0].l});
            end
            if (out_valid_o && out_ready_i) dut_beats++;
            if (q.size() != 0 && out_ready_i) void'(q.pop_front());
            if (in_valid_i && exp_ir) begin
                for (int k = 0; k <= int'(in_last_i); k++) begin
                    b.d = in_data_i[k*OUT_W +: OUT_W];
                    b.f = (k == 0);
                    b.l = (k == int'(in_last_i));
                    q.push_back(b);
                    pushed++;
                end
            end
            tick();
        end

        // drain whatever remains
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("drain_valid", {63'b0, out_valid_o}, {63'b0, q.size() != 0});
            if (q.size() != 0) begin
                chk("drain_data", {48'b0, out_data_o}, {48'b0, q[0].d});
                void'(q.pop_front());
            end
            if (out_valid_o) dut_beats++;
            tick();
        end
        chk("beat_count", 64'(dut_beats), 64'(pushed));
        chk("final_idle", {63'b0, out_valid_o}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vproc_deq_serializer.md
Name: vproc_deq_serializer

Overview:
- Reader-side companion to the vector unit's buffering queues: dequeues one wide entry at a time and emits it as a sequence of narrower beats to a downstream consumer.
- Typical use: a load/store or result path drains a wide queue into a narrower datapath.
- Registered output; sustains one beat per cycle with no bubble between consecutive entries.

Parameters:
IN_W, 64, width of one dequeued entry in bits; must be an integer multiple of OUT_W.
OUT_W, 16, width of one output beat in bits.
R (derived, localparam), IN_W/OUT_W, beats per entry; R >= 2 (elaboration error otherwise).

Ports:
clk_i  input  1  clock, all state on rising edge
sync_rst_i  input  1  reset, synchronous, active-high
in_valid_i  input  1  entry available from upstream queue
in_ready_o  output  1  entry accepted this cycle when in_valid_i & in_ready_o
in_data_i  input  IN_W  entry data; beat k is bits [k*OUT_W +: OUT_W]
in_last_i  input  $clog2(R)  index of last valid beat in entry (0..R-1)
out_valid_o  output  1  beat valid
out_ready_i  input  1  downstream accepts beat when out_valid_o & out_ready_i
out_data_o  output  OUT_W  current beat
out_first_o  output  1  current beat is beat 0 of its entry
out_last_o  output  1  current beat is last beat of its entry
busy_o  output  1  an entry is held (equals out_valid_o)

Behaviour:
- Reset is synchronous and active-high on sync_rst_i; the block has one clock, clk_i. Reset state: holding register empty, beat index 0, out_valid_o=0, out_first_o=0, out_last_o=0, busy_o=0, in_ready_o=1 (out_data_o don't-care).
- State: valid_q, data_q[IN_W], last_q[$clog2(R)], idx_q[$clog2(R)].
- out_valid_o = valid_q; out_data_o = data_q[idx_q*OUT_W +: OUT_W]; out_first_o = valid_q & (idx_q==0); out_last_o = valid_q & (idx_q==last_q).
- in_ready_o = ~valid_q | (out_last_o & out_ready_i): combinational through out_ready_i, no combinational path from in_valid_i.
- Accept (in_valid_i & in_ready_o): data_q<=in_data_i, last_q<=in_last_i, idx_q<=0, valid_q<=1.
- Beat transfer without accept: if idx_q != last_q then idx_q<=idx_q+1; else valid_q<=0, idx_q<=0.
- Last-beat transfer with simultaneous accept: the accept wins, so a new entry loads with no idle cycle.
- Latency: entry accepted in cycle t -> beat 0 visible on out_valid_o in cycle t+1.
- Throughput: entry with in_last_i=L occupies L+1 output cycles when out_ready_i is held high.
- Backpressure: while out_ready_i=0, out_data_o, out_first_o, out_last_o and idx_q stay stable; valid never retracts.
- in_last_i=0: single-beat entry; out_first_o and out_last_o are both 1.
- idx_q never exceeds last_q, so no wrap past R-1.
- Reset mid-entry: the held entry is discarded and out_valid_o=0 the next cycle; no partial beats replay.
- Reset has priority over accept and transfer in the same cycle.

Test Plan:
- Reset, then IN_W=64, OUT_W=16, entry 0xDDDD_CCCC_BBBB_AAAA with in_last_i=3, out_ready_i=1 -> beats 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD on 4 consecutive cycles; first asserted on beat 0, last on beat 3; in_ready_o=1 in the beat-3 cycle.
- Two entries back to back (in_last_i=3 then 1), out_ready_i=1 -> 6 consecutive valid beats with no bubble; second entry's last asserted on its 2nd beat.
- in_last_i=0 entry 0x...1234 -> one beat 0x1234 with first=1 and last=1; next entry accepted in the same cycle.
- out_ready_i low for 5 cycles at beat 1 -> out_data_o is held at beat 1 and in_ready_o=0 throughout; resume -> beats 2, 3 follow.
- sync_rst_i pulsed while holding beat 2 of 4 -> out_valid_o=0 and in_ready_o=1 the next cycle; the next entry starts at beat 0.
- Random in_valid_i/out_ready_i for 10k cycles against a scoreboard -> beat order and data match, first/last flags are correct, and no beat is lost or duplicated.
